npu_irq_arbiter: RTL and testbench
==================================

NPU_IRQ_ARBITER -- requirements
Module: npu_irq_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 8, number of interrupt sources; legal range 2..256.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port src_irq  input  NUM_SRC  per-source interrupt lines, rising-edge sensitive.
REQ-005 Port mask_wr  input  1  mask register write strobe.
REQ-006 Port mask_wdata  input  NUM_SRC  new mask value; bit=1 blocks that source.
REQ-007 Port mask  output  NUM_SRC  current mask register.
REQ-008 Port clr_valid  input  1  end-of-service strobe from software or sequencer.
REQ-009 Port clr_id  input  8  source index whose service ends.
REQ-010 Port interrupt_req  output  1  request to the downstream interrupt controller.
REQ-011 Port interrupt_ack  input  1  acknowledge from the downstream controller.
REQ-012 Port interrupt_id  output  8  index of the granted source, zero-extended.
REQ-013 Port pending  output  NUM_SRC  latched, not-yet-granted interrupts.
REQ-014 Port in_service  output  1  high while the state is INSVC.

Function
REQ-015 Edge detection: src_q registers src_irq every cycle; rise = src_irq & ~src_q.
REQ-016 pending[i] is set on the clock edge at which rise[i]=1; repeated edges while pending[i]=1 coalesce without error.
REQ-017 eligible = pending & ~mask; masked sources remain pending and become eligible when unmasked.
REQ-018 FSM states: IDLE, REQ, INSVC; encoding is free.
REQ-019 IDLE: when eligible!=0, grant the first set bit scanning upward from rr_ptr with wrap from NUM_SRC-1 to 0; on that edge latch interrupt_id, clear the granted pending bit, and go to REQ.
REQ-020 IDLE with eligible==0 remains in IDLE.
REQ-021 REQ: interrupt_req=1 and interrupt_id held stable until interrupt_ack=1; on the ack edge go to INSVC, set rr_ptr=(id+1) mod NUM_SRC, and deassert interrupt_req after that edge.
REQ-022 interrupt_req is registered, is 1 only in REQ, and interrupt_ack outside REQ is ignored.
REQ-023 INSVC: clr_valid=1 with clr_id==interrupt_id returns the FSM to IDLE on that edge; a mismatched clr_id or any clr_valid outside INSVC is ignored.
REQ-024 Latency: a rise sampled at edge N in IDLE with mask clear gives interrupt_req=1 after edge N+1; IDLE re-arbitrates on the cycle after a clear, with no idle bubble beyond that.
REQ-025 A new rise on the in-service source sets its pending bit again; it is re-granted only after the current service ends.
REQ-026 If a grant clear and a rise hit the same pending bit on the same edge, the set wins.
REQ-027 mask_wr updates mask on its edge; arbitration on that same edge uses the old mask value.
REQ-028 A mask write does not revoke a grant already in REQ or INSVC.
REQ-029 interrupt_id holds its last granted value in IDLE.

Reset
REQ-030 While rst=1 at a clock edge: state=IDLE, pending=0, src_q=0, mask=0, rr_ptr=0, interrupt_id=0, interrupt_req=0, in_service=0.
REQ-031 A reset asserted in REQ or INSVC aborts the service; interrupt_req is 0 after the reset edge, and no ack or clear is required.
REQ-032 A source held high through reset release is seen as a rise on the first edge after release, because src_q resets to 0.

Verification
REQ-033 Single source: rise src_irq[3] at edge N -> interrupt_req=1, interrupt_id=3 after N+1; ack -> req=0, in_service=1; clr_id=3 -> IDLE.
REQ-034 Round-robin: sources 1, 2 and 5 all pending with rr_ptr=0 -> grants 1, 2, 5 in order; then re-raise 1 and 5 -> grants 5, then 1 (rr_ptr=3).
REQ-035 Mask: mask=0x10 with rise on 4 -> no req, pending[4]=1; write mask=0 -> req with id 4 on the following cycles.
REQ-036 Clear mismatch and coalescing: in INSVC on id 2, clr_id=6 -> stays INSVC; two rises on source 7 meanwhile -> pending[7]=1 with exactly one later grant.
REQ-037 Reset mid-REQ: rst during REQ with id 5 -> interrupt_req=0, pending=0, mask=0 after the edge; with src_irq[5] still high, it re-pends after release per REQ-032.
REQ-038 Same-edge set/clear: rise on the granted source at its grant edge -> pending bit is 1 afterwards; ack with no req outstanding -> no state change.

Source files
------------

// File: rtl/npu_irq_arbiter.sv
// Round-robin interrupt arbiter: edge-detects sources, latches pending bits,
// grants one eligible source at a time and holds it until ack and clear.
module npu_irq_arbiter #(
   parameter int NUM_SRC = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_irq,
   input  logic               mask_wr,
   input  logic [NUM_SRC-1:0] mask_wdata,
   output logic [NUM_SRC-1:0] mask,
   input  logic               clr_valid,
   input  logic [7:0]         clr_id,
   output logic               interrupt_req,
   input  logic               interrupt_ack,
   output logic [7:0]         interrupt_id,
   output logic [NUM_SRC-1:0] pending,
   output logic               in_service
);

   localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      INSVC = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [NUM_SRC-1:0] srcPrev_q;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [PW-1:0]      rrPtr_q, rrPtr_d;
   logic [7:0]         id_q, id_d;
   logic               req_q, insvc_q;

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] eligible;
   logic               grantValid;
   logic [PW-1:0]      grantIdx;

   assign rise     = src_irq & ~srcPrev_q;
   assign eligible = pending_q & ~mask_q;

   // First eligible source scanning upward from rrPtr_q, wrapping at NUM_SRC-1.
   always_comb begin
      int idx;
      grantValid = 1'b0;
      grantIdx   = '0;
      idx        = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = int'(rrPtr_q) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (!grantValid && eligible[idx]) begin
            grantValid = 1'b1;
            grantIdx   = idx[PW-1:0];
         end
      end
   end

   always_comb begin
      int nxt;
      logic [NUM_SRC-1:0] grantClr;
      state_d  = state_q;
      mask_d   = mask_wr ? mask_wdata : mask_q;
      rrPtr_d  = rrPtr_q;
      id_d     = id_q;
      grantClr = '0;
      nxt      = int'(id_q) + 1;
      if (nxt >= NUM_SRC) nxt = 0;
      case (state_q)
         IDLE: begin
            if (grantValid) begin
               id_d               = 8'(grantIdx);
               grantClr[grantIdx] = 1'b1;
               state_d            = REQ;
            end
         end
         REQ: begin
            if (interrupt_ack) begin
               rrPtr_d = nxt[PW-1:0];
               state_d = INSVC;
            end
         end
         INSVC: begin
            if (clr_valid && (clr_id == id_q)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A rise on the same edge as the grant clear keeps the bit set.
      pending_d = (pending_q & ~grantClr) | rise;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         srcPrev_q <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         rrPtr_q   <= '0;
         id_q      <= '0;
         req_q     <= 1'b0;
         insvc_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         srcPrev_q <= src_irq;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         rrPtr_q   <= rrPtr_d;
         id_q      <= id_d;
         req_q     <= (state_d == REQ);
         insvc_q   <= (state_d == INSVC);
      end
   end

   assign mask          = mask_q;
   assign pending       = pending_q;
   assign interrupt_req = req_q;
   assign interrupt_id  = id_q;
   assign in_service    = insvc_q;

endmodule

// File: tb/tb_npu_irq_arbiter.sv
// Directed bench for npu_irq_arbiter: grant flow, round-robin order, masking,
// clear matching, coalescing, reset abort and same-edge set/clear.
module tb_npu_irq_arbiter;

   localparam int NUM_SRC = 8;

   logic               clk;
   logic               rst;
   logic [NUM_SRC-1:0] src_irq;
   logic               mask_wr;
   logic [NUM_SRC-1:0] mask_wdata;
   logic [NUM_SRC-1:0] mask;
   logic               clr_valid;
   logic [7:0]         clr_id;
   logic               interrupt_req;
   logic               interrupt_ack;
   logic [7:0]         interrupt_id;
   logic [NUM_SRC-1:0] pending;
   logic               in_service;

   int checks;
   int failures;

   npu_irq_arbiter #(.NUM_SRC(NUM_SRC)) dut (
      .clk           (clk),
      .rst           (rst),
      .src_irq       (src_irq),
      .mask_wr       (mask_wr),
      .mask_wdata    (mask_wdata),
      .mask          (mask),
      .clr_valid     (clr_valid),
      .clr_id        (clr_id),
      .interrupt_req (interrupt_req),
      .interrupt_ack (interrupt_ack),
      .interrupt_id  (interrupt_id),
      .pending       (pending),
      .in_service    (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges; outputs are then observed 1 time unit later.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // From IDLE with the source pending: grant, ack, then matching clear.
   task automatic grantCycle(input int expId);
      applyStimulus(1);
      checkOutput($sformatf("grant_req_%0d", expId), 32'(interrupt_req), 32'd1);
      checkOutput($sformatf("grant_id_%0d", expId), 32'(interrupt_id), 32'(expId));
      interrupt_ack = 1'b1;
      applyStimulus(1);
      interrupt_ack = 1'b0;
      checkOutput($sformatf("ack_req_%0d", expId), 32'(interrupt_req), 32'd0);
      checkOutput($sformatf("ack_insvc_%0d", expId), 32'(in_service), 32'd1);
      clr_valid = 1'b1;
      clr_id    = 8'(expId);
      applyStimulus(1);
      clr_valid = 1'b0;
      checkOutput($sformatf("clr_insvc_%0d", expId), 32'(in_service), 32'd0);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      src_irq       = '0;
      mask_wr       = 1'b0;
      mask_wdata    = '0;
      clr_valid     = 1'b0;
      clr_id        = '0;
      interrupt_ack = 1'b0;
      applyStimulus(2);
      rst = 1'b0;
      checkOutput("rst_req", 32'(interrupt_req), 32'd0);
      checkOutput("rst_id", 32'(interrupt_id), 32'd0);
      checkOutput("rst_pending", 32'(pending), 32'd0);
      checkOutput("rst_mask", 32'(mask), 32'd0);
      checkOutput("rst_insvc", 32'(in_service), 32'd0);

      // Single source 3: pend at edge N, request after N+1.
      src_irq = 8'h08;
      applyStimulus(1);
      checkOutput("single_pend", 32'(pending), 32'h08);
      checkOutput("single_noreq", 32'(interrupt_req), 32'd0);
      src_irq = 8'h00;
      grantCycle(3);
      checkOutput("single_pend_after", 32'(pending), 32'h00);

      // Round robin from rr_ptr=0 over sources 1, 2, 5.
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      src_irq = 8'h26;
      applyStimulus(1);
      checkOutput("rr_pend", 32'(pending), 32'h26);
      src_irq = 8'h00;
      grantCycle(1);
      grantCycle(2);
      grantCycle(5);
      // Bring rr_ptr to 3 via source 2, then 1 and 5 pending -> 5 before 1.
      src_irq = 8'h04;
      applyStimulus(1);
      src_irq = 8'h00;
      grantCycle(2);
      src_irq = 8'h22;
      applyStimulus(1);
      checkOutput("rr2_pend", 32'(pending), 32'h22);
      src_irq = 8'h00;
      grantCycle(5);
      grantCycle(1);

      // Mask holds source 4 pending; the unmasking edge still uses the old mask.
      mask_wr    = 1'b1;
      mask_wdata = 8'h10;
      applyStimulus(1);
      mask_wr = 1'b0;
      checkOutput("mask_val", 32'(mask), 32'h10);
      src_irq = 8'h10;
      applyStimulus(1);
      src_irq = 8'h00;
      applyStimulus(1);
      checkOutput("mask_noreq", 32'(interrupt_req), 32'd0);
      checkOutput("mask_pend", 32'(pending), 32'h10);
      mask_wr    = 1'b1;
      mask_wdata = 8'h00;
      applyStimulus(1);
      mask_wr = 1'b0;
      checkOutput("unmask_edge_noreq", 32'(interrupt_req), 32'd0);
      checkOutput("unmask_val", 32'(mask), 32'h00);
      grantCycle(4);

      // In service on 2: mismatched clear ignored, source 7 rises twice.
      src_irq = 8'h04;
      applyStimulus(2);
      src_irq = 8'h00;
      interrupt_ack = 1'b1;
      applyStimulus(1);
      interrupt_ack = 1'b0;
      checkOutput("mis_insvc_id", 32'(interrupt_id), 32'd2);
      clr_valid = 1'b1;
      clr_id    = 8'd6;
      src_irq   = 8'h80;
      applyStimulus(1);
      clr_valid = 1'b0;
      checkOutput("mis_stay_insvc", 32'(in_service), 32'd1);
      checkOutput("coal_pend1", 32'(pending), 32'h80);
      src_irq = 8'h00;
      applyStimulus(1);
      src_irq = 8'h80;
      applyStimulus(1);
      src_irq = 8'h00;
      checkOutput("coal_pend2", 32'(pending), 32'h80);
      clr_valid = 1'b1;
      clr_id    = 8'd2;
      applyStimulus(1);
      clr_valid = 1'b0;
      checkOutput("mis_clr_done", 32'(in_service), 32'd0);
      grantCycle(7);
      applyStimulus(1);
      checkOutput("coal_once_req", 32'(interrupt_req), 32'd0);
      checkOutput("coal_once_pend", 32'(pending), 32'h00);

      // Reset during REQ on 5, with source 5 held high through release.
      src_irq = 8'h20;
      applyStimulus(2);
      checkOutput("rreq_req", 32'(interrupt_req), 32'd1);
      checkOutput("rreq_id", 32'(interrupt_id), 32'd5);
      clr_valid = 1'b1;
      clr_id    = 8'd5;
      applyStimulus(1);
      clr_valid = 1'b0;
      checkOutput("clr_in_req_ignored", 32'(interrupt_req), 32'd1);
      mask_wr    = 1'b1;
      mask_wdata = 8'hFF;
      applyStimulus(1);
      mask_wr = 1'b0;
      checkOutput("mask_no_revoke", 32'(interrupt_req), 32'd1);
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      checkOutput("rreq_rst_req", 32'(interrupt_req), 32'd0);
      checkOutput("rreq_rst_pend", 32'(pending), 32'h00);
      checkOutput("rreq_rst_mask", 32'(mask), 32'h00);
      checkOutput("rreq_rst_id", 32'(interrupt_id), 32'd0);
      applyStimulus(1);
      checkOutput("rreq_repend", 32'(pending), 32'h20);
      checkOutput("rreq_repend_noreq", 32'(interrupt_req), 32'd0);
      src_irq = 8'h00;
      grantCycle(5);

      // Same-edge set/clear: source 3 pends while 6 is in service, rises again at its grant.
      src_irq = 8'h40;
      applyStimulus(2);
      src_irq = 8'h00;
      interrupt_ack = 1'b1;
      applyStimulus(1);
      interrupt_ack = 1'b0;
      src_irq = 8'h08;
      applyStimulus(1);
      src_irq = 8'h00;
      clr_valid = 1'b1;
      clr_id    = 8'd6;
      applyStimulus(1);
      clr_valid = 1'b0;
      checkOutput("same_pend_pre", 32'(pending), 32'h08);
      src_irq = 8'h08;
      grantCycle(3);
      src_irq = 8'h00;
      checkOutput("same_pend_kept", 32'(pending), 32'h08);
      grantCycle(3);
      checkOutput("same_id_hold", 32'(interrupt_id), 32'd3);

      // Ack with nothing outstanding changes nothing.
      interrupt_ack = 1'b1;
      applyStimulus(1);
      interrupt_ack = 1'b0;
      checkOutput("stray_ack_req", 32'(interrupt_req), 32'd0);
      checkOutput("stray_ack_insvc", 32'(in_service), 32'd0);
      checkOutput("stray_ack_id", 32'(interrupt_id), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
